// File: rtl/ncap_intr_ctrl.sv
// Interrupt controller for the NCAP rate monitor: latches and coalesces monitor events,
// rate-limits them and delivers each as an MSI with a type-specific vector.
module ncap_intr_ctrl #(
    parameter int VEC_HIGH = 0,
    parameter int VEC_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] holdoff_cycles,
    input  logic [31:0] ack_timeout,
    input  logic        interrupt,
    input  logic        interrupt_type,
    output logic        msi_req,
    output logic [4:0]  msi_vector,
    input  logic        msi_grant,
    input  logic        host_ack,
    output logic        status_valid,
    output logic        status_type,
    output logic [31:0] high_count,
    output logic [31:0] low_count,
    output logic [31:0] superseded_count,
    output logic [31:0] timeout_count
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_REQ     = 4'b0010,
        S_WAIT    = 4'b0100,
        S_HOLDOFF = 4'b1000
    } state_t;

    localparam int NUM_STATS = 4;

    state_t      state_reg, state_next;
    logic [31:0] phase_cnt_reg;
    logic        pend_valid_reg, pend_type_reg;
    logic        cur_type_reg;
    logic [4:0]  msi_vector_reg;
    logic        status_valid_reg, status_type_reg;

    logic        consume;
    logic        ack_taken;
    logic        timeout_hit;
    logic        hold_done;
    logic [31:0] hold_limit;

    // Statistic slots: 0 = high, 1 = low, 2 = superseded, 3 = timeout
    logic [31:0] stat_reg [NUM_STATS];
    logic        stat_inc [NUM_STATS];

    assign consume     = (state_reg == S_IDLE) && pend_valid_reg && enable;
    assign ack_taken   = (state_reg == S_WAIT) && host_ack;
    assign timeout_hit = (state_reg == S_WAIT) && !host_ack && (ack_timeout != 32'd0)
                         && (phase_cnt_reg >= ack_timeout - 32'd1);
    assign hold_limit  = (holdoff_cycles == 32'd0) ? 32'd1 : holdoff_cycles;
    assign hold_done   = phase_cnt_reg >= hold_limit - 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:    if (consume) state_next = S_REQ;
            S_REQ:     if (msi_grant) state_next = S_WAIT;
            S_WAIT:    if (ack_taken || timeout_hit) state_next = S_HOLDOFF;
            S_HOLDOFF: if (hold_done) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        msi_req      = (state_reg == S_REQ);
        msi_vector   = msi_vector_reg;
        status_valid = status_valid_reg;
        status_type  = status_type_reg;
    end

    // Shared phase counter: restarts on every state change, saturates so "wait forever" never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt_reg <= 32'd0;
        end else if (state_next != state_reg) begin
            phase_cnt_reg <= 32'd0;
        end else if (phase_cnt_reg != 32'hFFFF_FFFF) begin
            phase_cnt_reg <= phase_cnt_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_reg   <= 1'b0;
            pend_type_reg    <= 1'b0;
            cur_type_reg     <= 1'b0;
            msi_vector_reg   <= 5'd0;
            status_valid_reg <= 1'b0;
            status_type_reg  <= 1'b0;
        end else begin
            if (interrupt) begin
                pend_valid_reg <= 1'b1;
                pend_type_reg  <= interrupt_type;
            end else if (consume) begin
                pend_valid_reg <= 1'b0;
            end

            if (consume) begin
                cur_type_reg   <= pend_type_reg;
                msi_vector_reg <= pend_type_reg ? 5'(VEC_HIGH) : 5'(VEC_LOW);
            end

            if (state_reg == S_REQ && msi_grant) begin
                status_valid_reg <= 1'b1;
                status_type_reg  <= cur_type_reg;
            end else if (ack_taken || timeout_hit) begin
                status_valid_reg <= 1'b0;
            end
        end
    end

    assign stat_inc[0] = interrupt && interrupt_type;
    assign stat_inc[1] = interrupt && !interrupt_type;
    assign stat_inc[2] = interrupt && pend_valid_reg && !consume;
    assign stat_inc[3] = timeout_hit;

    generate
        for (genvar gi = 0; gi < NUM_STATS; gi++) begin : g_stat
            always_ff @(posedge clk) begin
                if (rst) begin
                    stat_reg[gi] <= 32'd0;
                end else if (stat_inc[gi] && stat_reg[gi] != 32'hFFFF_FFFF) begin
                    stat_reg[gi] <= stat_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign high_count       = stat_reg[0];
    assign low_count        = stat_reg[1];
    assign superseded_count = stat_reg[2];
    assign timeout_count    = stat_reg[3];

endmodule

// File: tb/tb_ncap_intr_ctrl.sv
// Directed bench for ncap_intr_ctrl: hand-computed expectations checked with immediate assertions.
module tb_ncap_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] holdoff_cycles;
    logic [31:0] ack_timeout;
    logic        interrupt;
    logic        interrupt_type;
    logic        msi_req;
    logic [4:0]  msi_vector;
    logic        msi_grant;
    logic        host_ack;
    logic        status_valid;
    logic        status_type;
    logic [31:0] high_count;
    logic [31:0] low_count;
    logic [31:0] superseded_count;
    logic [31:0] timeout_count;

    int n_cmp = 0;
    int n_err = 0;

    ncap_intr_ctrl #(.VEC_HIGH(0), .VEC_LOW(1)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .holdoff_cycles   (holdoff_cycles),
        .ack_timeout      (ack_timeout),
        .interrupt        (interrupt),
        .interrupt_type   (interrupt_type),
        .msi_req          (msi_req),
        .msi_vector       (msi_vector),
        .msi_grant        (msi_grant),
        .host_ack         (host_ack),
        .status_valid     (status_valid),
        .status_type      (status_type),
        .high_count       (high_count),
        .low_count        (low_count),
        .superseded_count (superseded_count),
        .timeout_count    (timeout_count)
    );

    always #5 clk = ~clk;

    // Advance one edge; sampling and driving happen 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        interrupt = 1'b0;
        msi_grant = 1'b0;
        host_ack = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Wait (bounded) until msi_req is high; an expired bound is a failed comparison.
    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (msi_req !== 1'b1 && k < 64) begin
            step();
            k++;
        end
        chk(tag, 32'(msi_req), 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        enable         = 1'b1;
        holdoff_cycles = 32'd1;
        ack_timeout    = 32'd0;
        interrupt      = 1'b0;
        interrupt_type = 1'b0;
        msi_grant      = 1'b0;
        host_ack       = 1'b0;
        step();
        step();
        chk("rst_req", 32'(msi_req), 32'd0);
        chk("rst_vec", 32'(msi_vector), 32'd0);
        chk("rst_sv", 32'(status_valid), 32'd0);
        chk("rst_st", 32'(status_type), 32'd0);
        chk("rst_cnt", high_count | low_count | superseded_count | timeout_count, 32'd0);
        rst = 1'b0;
        step();

        // Type-1 event: request one edge after capture, grant 3 cycles later, ack 10 later
        interrupt = 1'b1; interrupt_type = 1'b1;
        step();
        interrupt = 1'b0;
        chk("t1_req_early", 32'(msi_req), 32'd0);
        step();
        chk("t1_req", 32'(msi_req), 32'd1);
        chk("t1_vec", 32'(msi_vector), 32'd0);
        chk("t1_high", high_count, 32'd1);
        step();
        step();
        chk("t1_req_held", 32'(msi_req), 32'd1);
        msi_grant = 1'b1;
        step();
        msi_grant = 1'b0;
        chk("t1_req_drop", 32'(msi_req), 32'd0);
        chk("t1_sv", 32'(status_valid), 32'd1);
        chk("t1_st", 32'(status_type), 32'd1);
        repeat (9) step();
        chk("t1_sv_hold", 32'(status_valid), 32'd1);
        host_ack = 1'b1;
        step();
        host_ack = 1'b0;
        chk("t1_sv_ack", 32'(status_valid), 32'd0);
        step();
        step();

        // Holdoff of 20 cycles between deliveries
        holdoff_cycles = 32'd20;
        interrupt = 1'b1; interrupt_type = 1'b0;
        step();
        interrupt = 1'b0;
        step();
        chk("t2_req", 32'(msi_req), 32'd1);
        chk("t2_vec_lo", 32'(msi_vector), 32'd1);
        msi_grant = 1'b1;
        step();
        msi_grant = 1'b0;
        chk("t2_st0", 32'(status_type), 32'd0);
        host_ack = 1'b1;
        step();
        host_ack = 1'b0;
        step();
        interrupt = 1'b1; interrupt_type = 1'b1;
        step();
        interrupt = 1'b0;
        for (int i = 3; i <= 20; i++) begin
            step();
            chk($sformatf("t2_hold_%0d", i), 32'(msi_req), 32'd0);
        end
        step();
        chk("t2_req2", 32'(msi_req), 32'd1);
        chk("t2_vec_hi", 32'(msi_vector), 32'd0);
        holdoff_cycles = 32'd1;
        msi_grant = 1'b1;
        step();
        msi_grant = 1'b0;
        host_ack = 1'b1;
        step();
        host_ack = 1'b0;
        step();

        // enable=0: latch and coalesce, deliver only the last event on re-enable
        enable = 1'b0;
        do_reset();
        interrupt = 1'b1; interrupt_type = 1'b1;
        step();
        interrupt_type = 1'b0;
        step();
        interrupt_type = 1'b1;
        step();
        interrupt = 1'b0;
        step();
        step();
        chk("t3_noreq", 32'(msi_req), 32'd0);
        chk("t3_sup", superseded_count, 32'd2);
        chk("t3_high", high_count, 32'd2);
        chk("t3_low", low_count, 32'd1);
        enable = 1'b1;
        step();
        chk("t3_req", 32'(msi_req), 32'd1);
        chk("t3_vec", 32'(msi_vector), 32'd0);
        msi_grant = 1'b1;
        step();
        msi_grant = 1'b0;
        chk("t3_st", 32'(status_type), 32'd1);
        host_ack = 1'b1;
        step();
        host_ack = 1'b0;
        step();
        step();
        chk("t3_single", 32'(msi_req), 32'd0);

        // Ack timeout of 50 cycles
        do_reset();
        ack_timeout = 32'd50;
        interrupt = 1'b1; interrupt_type = 1'b0;
        step();
        interrupt = 1'b0;
        step();
        msi_grant = 1'b1;
        step();
        msi_grant = 1'b0;
        chk("t4_sv", 32'(status_valid), 32'd1);
        repeat (49) step();
        chk("t4_sv49", 32'(status_valid), 32'd1);
        chk("t4_to49", timeout_count, 32'd0);
        step();
        chk("t4_sv50", 32'(status_valid), 32'd0);
        chk("t4_to", timeout_count, 32'd1);
        ack_timeout = 32'd0;
        step();
        step();

        // New event on the same edge the pending one is consumed
        do_reset();
        interrupt = 1'b1; interrupt_type = 1'b1;
        step();
        interrupt_type = 1'b0;
        step();
        interrupt = 1'b0;
        chk("t5_req1", 32'(msi_req), 32'd1);
        chk("t5_vec1", 32'(msi_vector), 32'd0);
        msi_grant = 1'b1;
        step();
        msi_grant = 1'b0;
        chk("t5_st1", 32'(status_type), 32'd1);
        host_ack = 1'b1;
        step();
        host_ack = 1'b0;
        wait_req("t5_req2");
        chk("t5_vec2", 32'(msi_vector), 32'd1);
        msi_grant = 1'b1;
        step();
        msi_grant = 1'b0;
        chk("t5_st2", 32'(status_type), 32'd0);
        chk("t5_sup", superseded_count, 32'd0);
        host_ack = 1'b1;
        step();
        host_ack = 1'b0;
        step();
        step();

        // Reset while requesting
        interrupt = 1'b1; interrupt_type = 1'b1;
        step();
        interrupt = 1'b0;
        step();
        chk("t6_req", 32'(msi_req), 32'd1);
        do_reset();
        chk("t6_req_rst", 32'(msi_req), 32'd0);
        chk("t6_cnt_rst", high_count | low_count | superseded_count | timeout_count, 32'd0);
        step();
        chk("t6_idle", 32'(msi_req), 32'd0);
        interrupt = 1'b1; interrupt_type = 1'b0;
        step();
        interrupt = 1'b0;
        wait_req("t6_req2");
        chk("t6_vec", 32'(msi_vector), 32'd1);
        msi_grant = 1'b1;
        step();
        msi_grant = 1'b0;
        chk("t6_sv", 32'(status_valid), 32'd1);
        chk("t6_st", 32'(status_type), 32'd0);
        chk("t6_low", low_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ncap_intr_ctrl.md
Name: ncap_intr_ctrl

Overview:
- Sits directly downstream of the NCAP rate monitor. Consumes its single-cycle `interrupt` pulse and `interrupt_type` bit (1 = go high-perf, 0 = go low-power).
- Latches, coalesces and rate-limits those events, then delivers each one as an MSI request with a type-specific vector.
- Holds a status word until the driver acknowledges it, and keeps per-type event statistics for the driver.

Parameters:
- VEC_HIGH, 0, MSI vector number used for INTR_HIGH (type 1) events
- VEC_LOW, 1, MSI vector number used for INTR_LOW (type 0) events

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  delivery enable from OS register; 0 = latch events but issue no MSI
- holdoff_cycles  in  32  minimum gap after a delivered interrupt before the next MSI
- ack_timeout  in  32  cycles to wait for host_ack; 0 = wait forever
- interrupt  in  1  event pulse from the monitor
- interrupt_type  in  1  event type, valid when interrupt=1
- msi_req  out  1  MSI request to the PCIe core
- msi_vector  out  5  vector for the current request
- msi_grant  in  1  PCIe core accepted the request
- host_ack  in  1  single-cycle pulse when the driver clears the status
- status_valid  out  1  an interrupt has been delivered and not yet acknowledged
- status_type  out  1  type of the delivered interrupt
- high_count  out  32  total type-1 events received
- low_count  out  32  total type-0 events received
- superseded_count  out  32  pending events overwritten before delivery
- timeout_count  out  32  deliveries closed by ack timeout

Behaviour:
- Reset: state IDLE; msi_req=0, msi_vector=0, status_valid=0, status_type=0; all counters 0; pending cleared. Reset mid-handshake drops msi_req in the next cycle with no further action.
- Event capture:
  - On every edge with interrupt=1: pend_valid<=1, pend_type<=interrupt_type.
  - high_count or low_count increments by 1, independent of state and enable.
- Supersede: if pend_valid is already 1 and is not being consumed in the same cycle, the new type overwrites the old one and superseded_count increments.
- Consume collision: if the pending event is consumed in the same cycle a new event arrives, the new event becomes pending. It is not counted as superseded.
- All counters are 32-bit and saturate at 0xFFFFFFFF; they never wrap.
- State machine (registered, one-hot: IDLE, REQ, WAIT_HOST, HOLDOFF):
  - IDLE: if pend_valid && enable, go to REQ. In the same edge, cur_type<=pend_type, pend_valid is cleared, and msi_vector<=VEC_HIGH/VEC_LOW per cur_type.
  - REQ:
    - msi_req=1, and msi_vector is held stable.
    - When msi_grant=1 on an edge, go to WAIT_HOST; msi_req<=0, status_valid<=1, status_type<=cur_type.
    - enable falling during REQ does not abort the request.
  - WAIT_HOST:
    - A wait counter starts at 0. On host_ack=1, go to HOLDOFF with status_valid<=0.
    - Otherwise, if ack_timeout!=0 and the wait counter reaches ack_timeout-1, go to HOLDOFF with status_valid<=0 and timeout_count incremented.
    - If host_ack and the timeout occur on the same edge, ack wins and timeout_count is not incremented.
  - HOLDOFF: stays max(holdoff_cycles,1) cycles, then returns to IDLE. Events arriving here are latched/superseded normally.
- Latency:
  - Event sampled at edge N in IDLE with enable=1: msi_req is high after edge N+1.
  - msi_grant sampled at edge M: status_valid is high after edge M.
- msi_grant outside REQ and host_ack outside WAIT_HOST are ignored.
- holdoff_cycles and ack_timeout are sampled live. Changing them mid-phase affects the remaining count comparison only.
- enable=0 in IDLE: pending persists (with supersede counting) until enable returns to 1.

Test Plan:
- Reset, then type-1 pulse, grant after 3 cycles, host_ack after 10 → msi_req high 1 cycle after the event edge with msi_vector=0; status_valid=1, status_type=1 until ack; high_count=1.
- holdoff_cycles=20; type-0 pulse delivered and acked, second type-1 pulse 2 cycles after ack → second msi_req asserts no earlier than 20 cycles after the ack, with vector=1 then 0 in that order.
- enable=0; pulses type 1, 0, 1 → no msi_req; superseded_count=2, high_count=2, low_count=1. enable=1 → one MSI with vector=0 and status_type=1.
- ack_timeout=50, no host_ack after grant → status_valid drops exactly 50 cycles after entering WAIT_HOST; timeout_count=1.
- Pulse on the same edge IDLE consumes the pending event → two MSIs delivered in order, superseded_count=0.
- Assert rst while msi_req=1 → msi_req=0, all counters 0, state IDLE next cycle; a later pulse is delivered normally.
